unpad_stream: RTL and testbench



---
 rtl/unpad_stream.sv | 117 +++++++++++
 tb/tb_unpad_stream.sv | 273 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/unpad_stream.sv
// Captures one zero-padded feature map, strips its 1-element border and streams
// the interior out one channel per valid/ready beat; flags non-zero border data.
`ifndef DATA_LEN
`define DATA_LEN 16
`endif

module unpad_stream #(
  parameter int CH = 32,
  parameter int H  = 3,
  parameter int W  = 4
) (
  input  logic                                clk,
  input  logic                                rst_n,
  input  logic                                load,
  input  logic [CH*(H+2)*(W+2)*`DATA_LEN-1:0] d,
  output logic [H*W*`DATA_LEN-1:0]            q_data,
  output logic [$clog2(CH)-1:0]               q_ch,
  output logic                                q_valid,
  input  logic                                q_ready,
  output logic                                q_last,
  output logic                                busy,
  output logic                                done,
  output logic                                pad_err
);
  localparam int DL = `DATA_LEN;
  localparam int PW = W + 2;
  localparam int PE = (H + 2) * PW;
  localparam int BW = H * W * DL;
  localparam int CW = $clog2(CH);
  localparam logic [CW-1:0] LAST_CH = CW'(CH - 1);

  typedef enum logic {IDLE = 1'b0, SEND = 1'b1} state_e;

  state_e           state_q, state_d;
  logic [BW-1:0]    buf_q [CH];
  logic [CW-1:0]    ch_q, ch_d;
  logic             done_q, done_d;
  logic             pad_err_q, pad_err_d;
  logic [CH*BW-1:0] interior;
  logic [CH*PE-1:0] border_nz;
  logic             load_acc, beat_acc, last_beat;

  // Interior extraction and border inspection are pure wiring over d.
  generate
    for (genvar gi = 0; gi < CH; gi++) begin : g_ch
      for (genvar gr = 0; gr < H; gr++) begin : g_row
        for (genvar gc = 0; gc < W; gc++) begin : g_col
          assign interior[(gi*H*W + gr*W + gc)*DL +: DL] =
            d[(gi*PE + (gr+1)*PW + gc + 1)*DL +: DL];
        end
      end
      for (genvar ge = 0; ge < PE; ge++) begin : g_elem
        localparam int R = ge / PW;
        localparam int C = ge % PW;
        if (R == 0 || R == H + 1 || C == 0 || C == W + 1) begin : g_border
          assign border_nz[gi*PE + ge] = |d[(gi*PE + ge)*DL +: DL];
        end else begin : g_inner
          assign border_nz[gi*PE + ge] = 1'b0;
        end
      end
    end
  endgenerate

  assign load_acc  = (state_q == IDLE) && load;
  assign beat_acc  = q_valid && q_ready;
  assign last_beat = (ch_q == LAST_CH);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state_q <= IDLE;
    else        state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (load) state_d = SEND;
      SEND:    if (beat_acc && last_beat) state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    q_valid = (state_q == SEND);
    busy    = (state_q == SEND);
    q_last  = (state_q == SEND) && last_beat;
    q_ch    = ch_q;
    q_data  = buf_q[ch_q];
  end

  assign done    = done_q;
  assign pad_err = pad_err_q;

  // The counter parks at 0 after the final beat so it can never pass CH-1.
  always_comb begin
    ch_d = ch_q;
    if (load_acc)      ch_d = '0;
    else if (beat_acc) ch_d = last_beat ? '0 : ch_q + 1'b1;
    done_d    = beat_acc && last_beat;
    pad_err_d = load_acc ? |border_nz : pad_err_q;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < CH; i++) buf_q[i] <= '0;
      ch_q      <= '0;
      done_q    <= 1'b0;
      pad_err_q <= 1'b0;
    end else begin
      if (load_acc) begin
        for (int i = 0; i < CH; i++) buf_q[i] <= interior[i*BW +: BW];
      end
      ch_q      <= ch_d;
      done_q    <= done_d;
      pad_err_q <= pad_err_d;
    end
  end
endmodule

// File: tb/tb_unpad_stream.sv
// Directed self-checking bench for unpad_stream: crop, backpressure, border
// error flag, loads while busy, async reset mid-stream and idle hold.
`ifndef DATA_LEN
`define DATA_LEN 16
`endif

module tb_unpad_stream;
  localparam int CH = 32;
  localparam int H  = 3;
  localparam int W  = 4;
  localparam int DL = `DATA_LEN;
  localparam int PW = W + 2;
  localparam int PE = (H + 2) * PW;
  localparam int DW = CH * PE * DL;
  localparam int BW = H * W * DL;
  localparam int CW = $clog2(CH);

  logic          clk = 1'b0;
  logic          rst_n;
  logic          load;
  logic [DW-1:0] d;
  logic [BW-1:0] q_data;
  logic [CW-1:0] q_ch;
  logic          q_valid, q_ready, q_last, busy, done, pad_err;

  int pass_cnt  = 0;
  int total_cnt = 0;

  unpad_stream #(.CH(CH), .H(H), .W(W)) dut (
    .clk(clk), .rst_n(rst_n), .load(load), .d(d),
    .q_data(q_data), .q_ch(q_ch), .q_valid(q_valid), .q_ready(q_ready),
    .q_last(q_last), .busy(busy), .done(done), .pad_err(pad_err)
  );

  always #5 clk = ~clk;

  // Interior (ch,r,c) = base + ch*16 + r*4 + c + 1; optional single border element = 1.
  function automatic logic [DW-1:0] make_map(input int base, input int ech, input int er, input int ec);
    logic [DW-1:0] m;
    m = '0;
    for (int c = 0; c < CH; c++)
      for (int r = 0; r < H; r++)
        for (int k = 0; k < W; k++)
          m[(c*PE + (r+1)*PW + k + 1)*DL +: DL] = DL'(base + c*16 + r*4 + k + 1);
    if (ech >= 0) m[(ech*PE + er*PW + ec)*DL +: DL] = DL'(1);
    return m;
  endfunction

  function automatic logic [BW-1:0] exp_beat(input int base, input int c);
    logic [BW-1:0] e;
    for (int r = 0; r < H; r++)
      for (int k = 0; k < W; k++)
        e[(r*W + k)*DL +: DL] = DL'(base + c*16 + r*4 + k + 1);
    return e;
  endfunction

  task automatic next_cycle;
    @(posedge clk); #1;
  endtask

  task automatic load_map(input logic [DW-1:0] m);
    d = m; load = 1'b1;
    next_cycle();
    load = 1'b0;
  endtask

  task automatic test_reset;
    rst_n = 1'b0; load = 1'b0; q_ready = 1'b0; d = '0;
    repeat (2) @(posedge clk);
    #1;
    total_cnt++;
    if (q_valid !== 1'b0 || busy !== 1'b0 || done !== 1'b0 || pad_err !== 1'b0 || q_last !== 1'b0)
      $display("FAIL reset_ctrl: got v=%b b=%b d=%b p=%b l=%b, expected all 0", q_valid, busy, done, pad_err, q_last);
    else pass_cnt++;
    total_cnt++;
    if (q_data !== '0 || q_ch !== '0)
      $display("FAIL reset_data: got q_ch=%0d q_data=%h, expected 0", q_ch, q_data);
    else pass_cnt++;
    rst_n = 1'b1;
    next_cycle();
  endtask

  task automatic test_idle_hold;
    int bad = 0;
    q_ready = 1'b1;
    for (int i = 0; i < 50; i++) begin
      total_cnt++;
      if (q_valid !== 1'b0 || busy !== 1'b0 || done !== 1'b0) begin
        $display("FAIL idle_hold cyc %0d: got v=%b b=%b d=%b, expected 0 0 0", i, q_valid, busy, done);
        bad++;
      end else pass_cnt++;
      next_cycle();
    end
    $display("idle_hold: 50 cycles, %0d bad", bad);
  endtask

  task automatic test_basic_crop;
    q_ready = 1'b1;
    load_map(make_map(0, -1, 0, 0));
    for (int i = 0; i < CH; i++) begin
      total_cnt++;
      if (q_valid !== 1'b1 || q_ch !== CW'(i) || q_data !== exp_beat(0, i) || q_last !== (i == CH-1) || pad_err !== 1'b0)
        $display("FAIL crop_beat %0d: got v=%b ch=%0d l=%b p=%b data=%h, expected ch=%0d data=%h",
                 i, q_valid, q_ch, q_last, pad_err, q_data, i, exp_beat(0, i));
      else pass_cnt++;
      if (i == 5) begin
        total_cnt++;
        if (q_data[(2*W+3)*DL +: DL] !== 16'd92)
          $display("FAIL crop_ch5_r2c3: got %0d, expected 92", q_data[(2*W+3)*DL +: DL]);
        else pass_cnt++;
      end
      if (done !== 1'b0) begin
        total_cnt++;
        $display("FAIL crop_early_done beat %0d: got done=1, expected 0", i);
      end
      next_cycle();
    end
    total_cnt++;
    if (done !== 1'b1 || q_valid !== 1'b0 || busy !== 1'b0)
      $display("FAIL crop_done: got d=%b v=%b b=%b, expected 1 0 0", done, q_valid, busy);
    else pass_cnt++;
    next_cycle();
    total_cnt++;
    if (done !== 1'b0)
      $display("FAIL crop_done_pulse: got done=%b, expected 0", done);
    else pass_cnt++;
    $display("basic_crop: %0d beats streamed", CH);
  endtask

  task automatic test_backpressure;
    int e = 0, stall = 0, cyc = 0;
    load_map(make_map(0, -1, 0, 0));
    while (e < CH && cyc < 500) begin
      if (e == 7 && stall < 3) begin q_ready = 1'b0; stall++; end
      else if (e > 7) q_ready = 1'($urandom_range(0, 1));
      else q_ready = 1'b1;
      total_cnt++;
      if (q_valid !== 1'b1 || q_ch !== CW'(e) || q_data !== exp_beat(0, e))
        $display("FAIL bp_beat %0d cyc %0d: got v=%b ch=%0d data=%h, expected ch=%0d data=%h",
                 e, cyc, q_valid, q_ch, q_data, e, exp_beat(0, e));
      else pass_cnt++;
      if (q_ready) e++;
      next_cycle();
      cyc++;
    end
    q_ready = 1'b1;
    total_cnt++;
    if (e != CH || done !== 1'b1)
      $display("FAIL bp_complete: got beats=%0d done=%b, expected %0d 1", e, done, CH);
    else pass_cnt++;
    next_cycle();
    $display("backpressure: %0d beats in %0d cycles", e, cyc);
  endtask

  task automatic test_pad_error;
    q_ready = 1'b1;
    load_map(make_map(0, 3, 0, 2));
    for (int i = 0; i < CH; i++) begin
      total_cnt++;
      if (pad_err !== 1'b1 || q_valid !== 1'b1 || q_ch !== CW'(i) || q_data !== exp_beat(0, i))
        $display("FAIL pad_beat %0d: got p=%b v=%b ch=%0d data=%h, expected p=1 ch=%0d data=%h",
                 i, pad_err, q_valid, q_ch, q_data, i, exp_beat(0, i));
      else pass_cnt++;
      next_cycle();
    end
    total_cnt++;
    if (done !== 1'b1 || pad_err !== 1'b1)
      $display("FAIL pad_done: got done=%b p=%b, expected 1 1", done, pad_err);
    else pass_cnt++;
    load_map(make_map(0, -1, 0, 0));
    total_cnt++;
    if (pad_err !== 1'b0 || q_valid !== 1'b1)
      $display("FAIL pad_clear: got p=%b v=%b, expected 0 1", pad_err, q_valid);
    else pass_cnt++;
    repeat (CH) next_cycle();
    total_cnt++;
    if (done !== 1'b1)
      $display("FAIL pad_clear_done: got done=%b, expected 1", done);
    else pass_cnt++;
    next_cycle();
    $display("pad_error: flag set then cleared");
  endtask

  task automatic test_load_while_busy;
    logic [DW-1:0] map_b;
    map_b = make_map(1000, 0, 4, 5);
    q_ready = 1'b1;
    load_map(make_map(0, -1, 0, 0));
    for (int i = 0; i < CH; i++) begin
      if (i == 10 || i == CH-1) begin d = map_b; load = 1'b1; end
      else load = 1'b0;
      total_cnt++;
      if (q_valid !== 1'b1 || q_ch !== CW'(i) || q_data !== exp_beat(0, i) || pad_err !== 1'b0)
        $display("FAIL busy_beat %0d: got v=%b ch=%0d p=%b data=%h, expected ch=%0d p=0 data=%h",
                 i, q_valid, q_ch, pad_err, q_data, i, exp_beat(0, i));
      else pass_cnt++;
      next_cycle();
    end
    load = 1'b0;
    total_cnt++;
    if (done !== 1'b1 || busy !== 1'b0 || pad_err !== 1'b0)
      $display("FAIL busy_done: got d=%b b=%b p=%b, expected 1 0 0", done, busy, pad_err);
    else pass_cnt++;
    load_map(map_b);
    for (int i = 0; i < CH; i++) begin
      total_cnt++;
      if (q_valid !== 1'b1 || q_ch !== CW'(i) || q_data !== exp_beat(1000, i) || pad_err !== 1'b1)
        $display("FAIL busy_new_beat %0d: got v=%b ch=%0d p=%b data=%h, expected ch=%0d p=1 data=%h",
                 i, q_valid, q_ch, pad_err, q_data, i, exp_beat(1000, i));
      else pass_cnt++;
      next_cycle();
    end
    total_cnt++;
    if (done !== 1'b1)
      $display("FAIL busy_new_done: got done=%b, expected 1", done);
    else pass_cnt++;
    next_cycle();
    $display("load_while_busy: two ignored loads, done-cycle load accepted");
  endtask

  task automatic test_reset_mid_stream;
    q_ready = 1'b1;
    load_map(make_map(0, 5, 2, 0));
    repeat (15) next_cycle();
    total_cnt++;
    if (q_ch !== CW'(15) || pad_err !== 1'b1 || q_valid !== 1'b1)
      $display("FAIL rst_pre: got ch=%0d p=%b v=%b, expected 15 1 1", q_ch, pad_err, q_valid);
    else pass_cnt++;
    #2 rst_n = 1'b0;
    #1;
    total_cnt++;
    if (q_valid !== 1'b0 || busy !== 1'b0 || done !== 1'b0 || pad_err !== 1'b0 || q_ch !== '0 || q_data !== '0)
      $display("FAIL rst_async: got v=%b b=%b d=%b p=%b ch=%0d data=%h, expected all 0",
               q_valid, busy, done, pad_err, q_ch, q_data);
    else pass_cnt++;
    repeat (2) next_cycle();
    rst_n = 1'b1;
    for (int i = 0; i < 20; i++) begin
      total_cnt++;
      if (done !== 1'b0 || q_valid !== 1'b0)
        $display("FAIL rst_no_done cyc %0d: got d=%b v=%b, expected 0 0", i, done, q_valid);
      else pass_cnt++;
      next_cycle();
    end
    load_map(make_map(2000, -1, 0, 0));
    for (int i = 0; i < CH; i++) begin
      total_cnt++;
      if (q_valid !== 1'b1 || q_ch !== CW'(i) || q_data !== exp_beat(2000, i))
        $display("FAIL rst_fresh_beat %0d: got v=%b ch=%0d data=%h, expected ch=%0d data=%h",
                 i, q_valid, q_ch, q_data, i, exp_beat(2000, i));
      else pass_cnt++;
      next_cycle();
    end
    total_cnt++;
    if (done !== 1'b1)
      $display("FAIL rst_fresh_done: got done=%b, expected 1", done);
    else pass_cnt++;
    next_cycle();
    $display("reset_mid_stream: aborted at ch 15, fresh stream completed");
  endtask

  initial begin
    test_reset();
    test_idle_hold();
    test_basic_crop();
    test_backpressure();
    test_pad_error();
    test_load_while_busy();
    test_reset_mid_stream();
    $display("%0d/%0d checks passed", pass_cnt, total_cnt);
    $finish;
  end
endmodule
